// File: rtl/px_pkg.sv
// ============================================================================
// Module : px_pkg
// Brief  : Shared pixel types and 3x3 window index constants.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package px_pkg;

  localparam int PIX_W_DEF = 8;

  // Window element order: raster order inside the 3x3, oldest row first
  localparam int WIN_TL = 0;
  localparam int WIN_TC = 1;
  localparam int WIN_TR = 2;
  localparam int WIN_ML = 3;
  localparam int WIN_MC = 4;
  localparam int WIN_MR = 5;
  localparam int WIN_BL = 6;
  localparam int WIN_BC = 7;
  localparam int WIN_BR = 8;
  localparam int WIN_N  = 9;

  typedef logic [PIX_W_DEF-1:0] pixel_t;

endpackage

`default_nettype wire

// File: rtl/window_3x3_gen_if.sv
// ============================================================================
// Module : window_3x3_gen_if
// Brief  : Pixel-in / window-out handshake bundle for window_3x3_gen.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface window_3x3_gen_if
  import px_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF
) ();

  logic [PIX_W-1:0] pix_in;
  logic             pix_valid;
  logic             pix_ready;
  logic             win_valid;
  logic             win_ready;
  logic             frame_done;
  logic [PIX_W-1:0] add_1;
  logic [PIX_W-1:0] add_2;
  logic [PIX_W-1:0] add_3;
  logic [PIX_W-1:0] add_4;
  logic [PIX_W-1:0] add_5;
  logic [PIX_W-1:0] add_6;
  logic [PIX_W-1:0] add_7;
  logic [PIX_W-1:0] add_8;
  logic [PIX_W-1:0] add_9;

  modport slave (
    input  pix_in, pix_valid, win_ready,
    output pix_ready, win_valid, frame_done,
    output add_1, add_2, add_3, add_4, add_5, add_6, add_7, add_8, add_9
  );

  modport master (
    output pix_in, pix_valid, win_ready,
    input  pix_ready, win_valid, frame_done,
    input  add_1, add_2, add_3, add_4, add_5, add_6, add_7, add_8, add_9
  );

endinterface

`default_nettype wire

// File: rtl/line_buffer.sv
// ============================================================================
// Module : line_buffer
// Brief  : One image row of storage; combinational read and write share one
//          address, so a same-cycle read returns the previous row's pixel.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module line_buffer #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_addr,
  input  logic [WIDTH-1:0]         i_din,
  output logic [WIDTH-1:0]         o_dout
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_din;
    end
  end

  assign o_dout = r_mem[i_addr];

endmodule

`default_nettype wire

// File: rtl/window_3x3_gen.sv
// ============================================================================
// Module : window_3x3_gen
// Brief  : Streaming 3x3 neighbourhood generator with a one-deep registered
//          window output and valid/ready handshakes on both sides.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module window_3x3_gen
  import px_pkg::*;
#(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int PIX_W = PIX_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  window_3x3_gen_if.slave bus
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] C_COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] C_ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] C_COL_WIN  = CW'(2);
  localparam logic [RW-1:0] C_ROW_WIN  = RW'(2);

  logic [CW-1:0]    r_col;
  logic [RW-1:0]    r_row;
  logic             r_win_valid;
  logic             r_frame_done;
  logic [PIX_W-1:0] r_add   [WIN_N];
  logic [PIX_W-1:0] r_col_l [3];
  logic [PIX_W-1:0] r_col_m [3];
  logic [PIX_W-1:0] w_window [WIN_N];
  logic [PIX_W-1:0] w_top;
  logic [PIX_W-1:0] w_mid;
  logic             w_pix_ready;
  logic             w_accept;
  logic             w_consume;
  logic             w_win_hit;
  logic             w_frame_last;

  assign w_pix_ready  = !rst && (!r_win_valid || bus.win_ready);
  assign w_accept     = bus.pix_valid && w_pix_ready;
  assign w_consume    = r_win_valid && bus.win_ready;
  assign w_win_hit    = (r_row >= C_ROW_WIN) && (r_col >= C_COL_WIN);
  assign w_frame_last = (r_row == C_ROW_LAST) && (r_col == C_COL_LAST);

  // lb0 holds row r-2, lb1 holds row r-1; lb1 cascades into lb0
  line_buffer #(
    .DEPTH (IMG_W),
    .WIDTH (PIX_W)
  ) u_lb0 (
    .clk    (clk),
    .i_we   (w_accept),
    .i_addr (r_col),
    .i_din  (w_mid),
    .o_dout (w_top)
  );

  line_buffer #(
    .DEPTH (IMG_W),
    .WIDTH (PIX_W)
  ) u_lb1 (
    .clk    (clk),
    .i_we   (w_accept),
    .i_addr (r_col),
    .i_din  (bus.pix_in),
    .o_dout (w_mid)
  );

  // Window as it will look once the incoming column has shifted in
  assign w_window[WIN_TL] = r_col_l[0];
  assign w_window[WIN_TC] = r_col_m[0];
  assign w_window[WIN_TR] = w_top;
  assign w_window[WIN_ML] = r_col_l[1];
  assign w_window[WIN_MC] = r_col_m[1];
  assign w_window[WIN_MR] = w_mid;
  assign w_window[WIN_BL] = r_col_l[2];
  assign w_window[WIN_BC] = r_col_m[2];
  assign w_window[WIN_BR] = bus.pix_in;

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_col_l    <= r_col_m;
      r_col_m[0] <= w_top;
      r_col_m[1] <= w_mid;
      r_col_m[2] <= bus.pix_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col        <= '0;
      r_row        <= '0;
      r_win_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      for (int i = 0; i < WIN_N; i++) begin
        r_add[i] <= '0;
      end
    end else begin
      r_frame_done <= 1'b0;
      if (w_accept) begin
        if (r_col == C_COL_LAST) begin
          r_col <= '0;
          r_row <= (r_row == C_ROW_LAST) ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
        if (w_win_hit) begin
          r_add        <= w_window;
          r_win_valid  <= 1'b1;
          r_frame_done <= w_frame_last;
        end else if (w_consume) begin
          r_win_valid <= 1'b0;
        end
      end else if (w_consume) begin
        r_win_valid <= 1'b0;
      end
    end
  end

  assign bus.pix_ready  = w_pix_ready;
  assign bus.win_valid  = r_win_valid;
  assign bus.frame_done = r_frame_done;
  assign bus.add_1      = r_add[WIN_TL];
  assign bus.add_2      = r_add[WIN_TC];
  assign bus.add_3      = r_add[WIN_TR];
  assign bus.add_4      = r_add[WIN_ML];
  assign bus.add_5      = r_add[WIN_MC];
  assign bus.add_6      = r_add[WIN_MR];
  assign bus.add_7      = r_add[WIN_BL];
  assign bus.add_8      = r_add[WIN_BC];
  assign bus.add_9      = r_add[WIN_BR];

endmodule

`default_nettype wire
